// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the Wishbone master arbiter: FSM state encoding,
// requester identifiers and watchdog sizing.
package wb_master_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_BUS_IF   = 3'd1,
    ARB_BUS_MEM  = 3'd2,
    ARB_RESP_IF  = 3'd3,
    ARB_RESP_MEM = 3'd4
  } arb_state_e;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Counter must be able to hold TIMEOUT_CYCLES; keep at least one bit when disabled.
  function automatic int wdog_cnt_width(input int timeout_cycles);
    if (timeout_cycles < 1) begin
      return 1;
    end
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/wb_master_arbiter_if.sv
// Wishbone master-side bus bundle between the arbiter and the interconnect.
interface wb_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   wishbone_addr_o;
  logic [DATA_W-1:0]   wishbone_data_o;
  logic                wishbone_we_o;
  logic [DATA_W/8-1:0] wishbone_sel_o;
  logic                wishbone_stb_o;
  logic                wishbone_cyc_o;
  logic [DATA_W-1:0]   wishbone_data_i;
  logic                wishbone_ack_i;

  modport master (
    output wishbone_addr_o,
    output wishbone_data_o,
    output wishbone_we_o,
    output wishbone_sel_o,
    output wishbone_stb_o,
    output wishbone_cyc_o,
    input  wishbone_data_i,
    input  wishbone_ack_i
  );

  modport slave (
    input  wishbone_addr_o,
    input  wishbone_data_o,
    input  wishbone_we_o,
    input  wishbone_sel_o,
    input  wishbone_stb_o,
    input  wishbone_cyc_o,
    output wishbone_data_i,
    output wishbone_ack_i
  );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Bus-cycle watchdog: saturating counter that flags the last allowed cycle
// of a transaction. TIMEOUT_CYCLES=0 disables expiry.
module wb_arb_watchdog
  import wb_master_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = wdog_cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && (count_reg != {CNT_W{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // count_reg holds the number of bus cycles already completed, so the
  // TIMEOUT_CYCLES-th bus cycle is the one that sees LIMIT.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
      assign expired = en && (count_reg >= LIMIT);
    end else begin : g_no_wdog
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/wb_master_arbiter.sv
// Shares one Wishbone master port between instruction fetch and data memory.
// Define WB_ARB_ROUND_ROBIN_EN for alternating grants on ties (default: MEM priority).
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_data_o,
  output logic                if_stall_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_data_i,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic                mem_stall_o,
  wb_master_arbiter_if.master wishbone,
  output logic                timeout_o
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_e        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              we_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic              stb_reg;
  logic              cyc_reg;
  logic [DATA_W-1:0] if_data_reg;
  logic [DATA_W-1:0] mem_data_reg;
  logic              timeout_reg;
  logic              discard_reg;

  logic grant_mem;
  logic grant_if;
  logic in_bus;
  logic bus_is_mem;
  logic discard_now;
  logic wdog_expired;

`ifdef WB_ARB_ROUND_ROBIN_EN
  req_id_e last_grant_reg;
  // On a tie, hand the bus to whichever side did not get it last time.
  assign grant_mem = mem_req_i && (!if_req_i || (last_grant_reg == REQ_IF));
`else
  assign grant_mem = mem_req_i;
`endif
  assign grant_if = if_req_i && !grant_mem;

  assign in_bus      = (state_reg == ARB_BUS_IF) || (state_reg == ARB_BUS_MEM);
  assign bus_is_mem  = (state_reg == ARB_BUS_MEM);
  assign discard_now = discard_reg || flush_i;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_reg == ARB_IDLE),
    .en     (in_bus),
    .expired(wdog_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ARB_IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      sel_reg      <= '0;
      stb_reg      <= 1'b0;
      cyc_reg      <= 1'b0;
      if_data_reg  <= '0;
      mem_data_reg <= '0;
      timeout_reg  <= 1'b0;
      discard_reg  <= 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      last_grant_reg <= REQ_IF;
`endif
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          if (!flush_i && grant_mem) begin
            addr_reg  <= mem_addr_i;
            wdata_reg <= mem_data_i;
            we_reg    <= mem_we_i;
            sel_reg   <= mem_sel_i;
            stb_reg   <= 1'b1;
            cyc_reg   <= 1'b1;
            state_reg <= ARB_BUS_MEM;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_grant_reg <= REQ_MEM;
`endif
          end else if (!flush_i && grant_if) begin
            addr_reg  <= if_addr_i;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            sel_reg   <= {SEL_W{1'b1}};
            stb_reg   <= 1'b1;
            cyc_reg   <= 1'b1;
            state_reg <= ARB_BUS_IF;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_grant_reg <= REQ_IF;
`endif
          end
        end

        ARB_BUS_IF, ARB_BUS_MEM: begin
          // Ack takes precedence over a watchdog expiry in the same cycle.
          if (wishbone.wishbone_ack_i) begin
            cyc_reg     <= 1'b0;
            stb_reg     <= 1'b0;
            we_reg      <= 1'b0;
            discard_reg <= 1'b0;
            if (discard_now) begin
              state_reg <= ARB_IDLE;
            end else begin
              state_reg <= bus_is_mem ? ARB_RESP_MEM : ARB_RESP_IF;
              if (!we_reg) begin
                if (bus_is_mem) begin
                  mem_data_reg <= wishbone.wishbone_data_i;
                end else begin
                  if_data_reg <= wishbone.wishbone_data_i;
                end
              end
            end
          end else if (wdog_expired) begin
            cyc_reg     <= 1'b0;
            stb_reg     <= 1'b0;
            timeout_reg <= 1'b1;
            discard_reg <= 1'b0;
            if (discard_now) begin
              state_reg <= ARB_IDLE;
            end else begin
              state_reg <= bus_is_mem ? ARB_RESP_MEM : ARB_RESP_IF;
              if (bus_is_mem) begin
                mem_data_reg <= '0;
              end else begin
                if_data_reg <= '0;
              end
            end
          end else if (flush_i) begin
            discard_reg <= 1'b1;
          end
        end

        ARB_RESP_IF, ARB_RESP_MEM: begin
          state_reg <= ARB_IDLE;
        end

        default: begin
          state_reg <= ARB_IDLE;
        end
      endcase
    end
  end

  assign wishbone.wishbone_addr_o = addr_reg;
  assign wishbone.wishbone_data_o = wdata_reg;
  assign wishbone.wishbone_we_o   = we_reg;
  assign wishbone.wishbone_sel_o  = sel_reg;
  assign wishbone.wishbone_stb_o  = stb_reg;
  assign wishbone.wishbone_cyc_o  = cyc_reg;

  assign if_data_o  = if_data_reg;
  assign mem_data_o = mem_data_reg;
  assign timeout_o  = timeout_reg;

  // Stall releases only in the single response cycle of the owning requester.
  assign if_stall_o  = if_req_i && (state_reg != ARB_RESP_IF);
  assign mem_stall_o = mem_req_i && (state_reg != ARB_RESP_MEM);

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Shares the single Wishbone master port between the instruction-fetch requester and the data-memory requester.
- Sequences one bus transaction at a time and holds the bus until ack, timeout or flush resolution.
- Returns read data to the granted requester and drives per-requester stall requests to ctrl.
- Sits between the pc_reg/mem stages and the external Wishbone interconnect.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles without ack before abort; 0 disables the watchdog.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; sel width is DATA_W/8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- flush_i  in  1  pipeline flush from ctrl.
- if_req_i  in  1  fetch request, level.
- if_addr_i  in  ADDR_W  fetch address.
- if_data_o  out  DATA_W  fetched word, registered.
- if_stall_o  out  1  fetch stall request.
- mem_req_i  in  1  data request, level.
- mem_we_i  in  1  1=write.
- mem_sel_i  in  DATA_W/8  byte enables.
- mem_addr_i  in  ADDR_W  data address.
- mem_data_i  in  DATA_W  write data.
- mem_data_o  out  DATA_W  read data, registered.
- mem_stall_o  out  1  data stall request.
- wishbone_data_i  in  DATA_W  bus read data.
- wishbone_ack_i  in  1  bus ack.
- wishbone_addr_o  out  ADDR_W  bus address.
- wishbone_data_o  out  DATA_W  bus write data.
- wishbone_we_o  out  1  bus write enable.
- wishbone_sel_o  out  DATA_W/8  bus byte select.
- wishbone_stb_o  out  1  strobe.
- wishbone_cyc_o  out  1  cycle.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All Wishbone outputs 0, if_data_o=mem_data_o=0, timeout_o=0, counter 0, discard flag 0.
- Requester contract: hold req, addr, we, sel and data stable while its stall_o=1.
- Stall: x_stall_o = x_req_i AND NOT (state==RESP_x). Combinational.
- States: IDLE, BUS_IF, BUS_MEM, RESP_IF, RESP_MEM.
- IDLE, no flush_i:
  - mem_req_i has priority over if_req_i.
  - On grant, register addr/we/sel/data onto Wishbone, set cyc=stb=1, clear counter, go to BUS_x.
  - IF transactions always use we=0, sel=all ones, data 0.
- IDLE with flush_i=1: no grant that cycle.
- BUS_x:
  - Wishbone outputs held constant. Counter increments each cycle.
  - On wishbone_ack_i: cyc=stb=we=0.
  - If discard=0: latch wishbone_data_i into x_data_o (reads only; writes leave x_data_o unchanged) and go to RESP_x.
  - If discard=1: go to IDLE, clear discard, leave data unchanged.
  - flush_i in BUS_x sets discard. The bus transaction is never cut short by flush.
- RESP_x: one cycle, x_stall_o=0, data valid. Then IDLE. flush_i in RESP_x: same transition.
- Minimum latency: req seen cycle 0, cyc/stb cycle 1, ack cycle 1, stall low cycle 2, next grant cycle 3.
- Watchdog (TIMEOUT_CYCLES>0): counter reaching TIMEOUT_CYCLES with no ack:
  - Drop cyc/stb and pulse timeout_o.
  - Load x_data_o=0 and go to RESP_x, or IDLE if discard=1.
- Ack and timeout in the same cycle: ack wins, no timeout pulse.
- wishbone_ack_i outside BUS_x is ignored.
- Counter saturates and is 8 bits wide for the default; width is clog2(TIMEOUT_CYCLES+1).

Optional Feature:
- WB_ARB_ROUND_ROBIN_EN defined:
  - A last-grant bit is kept. When both requesters are pending in IDLE, the one not granted last wins.
  - The last-grant bit resets to IF, so MEM wins the first tie.
- Undefined: fixed MEM priority as above; an IF request can starve under continuous MEM traffic.

Decomposition:
- Shared package/defines: state encodings (ARB_IDLE, ARB_BUS_IF, ARB_BUS_MEM, ARB_RESP_IF, ARB_RESP_MEM), requester IDs, default TIMEOUT_CYCLES.
- Bus widths stay in defines.v (RegBus).
- One natural sub-module, wb_arb_watchdog: counter plus timeout compare, with clear/enable inputs and an expired output.

Test Plan:
- IF read at addr 0x00000100, ack after 2 cycles with data 0x24020005:
  - cyc/stb high 2 cycles, we=0, sel=4'hF.
  - if_stall_o low one cycle after ack, if_data_o=0x24020005.
- MEM and IF requests in the same cycle (MEM write 0x80000010, sel 4'h3, data 0xDEADBEEF):
  - MEM granted first; bus shows we=1, sel=3, data 0xDEADBEEF.
  - IF granted 2 cycles after MEM ack.
- flush_i pulse mid-IF transaction, ack 3 cycles later with data 0x12345678:
  - Bus held until ack; if_data_o unchanged.
  - No RESP cycle; state IDLE the cycle after ack.
- No ack with TIMEOUT_CYCLES=4:
  - cyc dropped after 4 bus cycles.
  - timeout_o high for exactly 1 cycle; mem_data_o=0; mem_stall_o low the next cycle.
- rst driven low mid-BUS_MEM (asynchronous, not clock-aligned):
  - All outputs 0 immediately.
  - After release, a late ack is ignored and state stays IDLE.
- WB_ARB_ROUND_ROBIN_EN defined, both requesters continuously pending:
  - Grants alternate MEM, IF, MEM, IF.
